// File: rtl/mpu_pkg.sv
// Shared MPU constants, loader state encoding and matrix element placement.
package mpu_pkg;

    localparam int unsigned MPU_ELEM_W    = 8;
    localparam int unsigned MPU_DIM       = 5;
    localparam int unsigned MPU_ELEMS     = 25;
    localparam int unsigned MPU_MATRIX_W  = 200;
    localparam int unsigned MPU_FRAME_LEN = 26;

    typedef enum logic {
        S_LOAD,
        S_FULL
    } mpu_state_e;

    // Bit offset of element (col,row) in the flattened matrix: column-major, row inner.
    function automatic int unsigned mpu_elem_offset(input int unsigned col, input int unsigned row);
        return MPU_ELEM_W * (row + MPU_DIM * col);
    endfunction

endpackage

// File: rtl/mpu_matrix_loader.sv
// Byte-stream to parallel frame loader: one signed factor plus a 5x5 signed matrix,
// held until the consumer accepts it, with end-of-frame framing check.
module mpu_matrix_loader
    import mpu_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [MPU_ELEM_W-1:0]      in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [MPU_ELEM_W-1:0]      out_factor,
    output logic [MPU_MATRIX_W-1:0]    out_matrix,
    output logic                       err
);

    mpu_state_e               state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic [MPU_ELEM_W-1:0]    factor_q, factor_d;
    logic [MPU_MATRIX_W-1:0]  matrix_q, matrix_d;
    logic                     xfer;
    logic                     last_slot;

    assign in_ready   = ~rst & (state_q == S_LOAD);
    assign out_valid  = (state_q == S_FULL);
    assign out_factor = factor_q;
    assign out_matrix = matrix_q;
    assign err        = err_q;

    assign xfer      = in_valid & in_ready;
    assign last_slot = (cnt_q == 5'(MPU_FRAME_LEN - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (xfer) begin
                    if (last_slot) begin
                        cnt_d = '0;
                        if (in_last) state_d = S_FULL;
                        else         err_d   = 1'b1;
                    end else if (in_last) begin
                        cnt_d = '0;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            S_FULL: begin
                if (out_ready) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    // An overlong byte arrives at slot 25 without in_last; it is discarded, not written.
    always_comb begin
        factor_d = factor_q;
        matrix_d = matrix_q;
        if (xfer && !(last_slot && !in_last)) begin
            if (cnt_q == 5'd0) factor_d = in_data;
            for (int unsigned col = 0; col < MPU_DIM; col++) begin
                for (int unsigned row = 0; row < MPU_DIM; row++) begin
                    if (cnt_q == 5'(row + MPU_DIM * col + 1))
                        matrix_d[mpu_elem_offset(col, row) +: MPU_ELEM_W] = in_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LOAD;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            factor_q <= '0;
            matrix_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            factor_q <= factor_d;
            matrix_q <= matrix_d;
        end
    end

endmodule

// File: doc/mpu_matrix_loader.md
# mpu_matrix_loader

- Input stage of the MPU scalar-multiply path.
- Takes a byte stream over a valid/ready handshake and assembles one frame: one signed 8-bit factor plus a 5x5 signed 8-bit matrix.
- Presents the frame in parallel as a flattened 200-bit matrix and an 8-bit factor, which drive the integer-multiply stage directly.
- Holds the frame until the consumer accepts it, and checks frame framing against an end-of-frame marker.

## Interface
- No parameters. Widths are fixed by package constants.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream byte valid.
- in_ready  out  1  loader can accept a byte.
- in_data  in  8  signed byte: factor or matrix element.
- in_last  in  1  marks the final byte of a frame.
- out_valid  out  1  complete frame is presented.
- out_ready  in  1  consumer accepts the frame.
- out_factor  out  8  signed factor of the presented frame.
- out_matrix  out  200  flattened 5x5 matrix. Element (col,row) sits at bits [8*(row+5*col) +: 8].
- err  out  1  one-cycle pulse: framing error, frame dropped.

## Operation
- Byte transfer occurs when in_valid && in_ready. Frame accept occurs when out_valid && out_ready.
- Frame is exactly 26 bytes:
  - byte 0 = factor;
  - byte k (k = 1..25) = element index e = k-1, written to out_matrix[8e +: 8].
  - Stream order is column-major, row inner: e = row + 5*col.
- 5-bit byte counter cnt, range 0..25.
- States:
  - S_LOAD: in_ready=1. Each transfer writes the byte at slot cnt.
    - cnt<25 and !in_last: cnt++.
    - cnt==25 and in_last: go to S_FULL, cnt=0.
    - cnt<25 and in_last (short frame): err pulse, cnt=0, stay in S_LOAD. Frame dropped.
    - cnt==25 and !in_last (long frame): err pulse, cnt=0, stay in S_LOAD. The byte is discarded and no frame is presented. The source must resynchronise with its next frame.
  - S_FULL: out_valid=1, in_ready=0. Outputs are stable. On frame accept, go to S_LOAD.
- While loading, out_matrix/out_factor reflect partially written data; they are meaningful only while out_valid=1. A dropped frame may leave partial overwrites; no clearing on error.
- No arithmetic is performed; bytes are stored bit-exact, with sign preserved.

## Timing
- Reset (rst=1 at a clock edge):
  - state=S_LOAD, cnt=0;
  - out_valid=0, err=0, out_factor=0, out_matrix=0.
  - in_ready=0 while rst is high. Transfers in reset cycles are ignored.
- in_ready and out_valid are combinational decodes of registered state (gated by rst for in_ready). No combinational path from in_valid or out_ready to any output.
- out_valid rises the cycle after the transfer of byte 25.
- Accept in cycle t: in_ready=1 in cycle t+1. Minimum frame period is 27 cycles: 26 load cycles plus 1 present cycle.
- err is registered and asserts the cycle after the offending transfer, for one cycle.
- Reset mid-frame or while in S_FULL: the frame is discarded, out_valid drops the next cycle, and no err is raised.
- in_last with in_valid=0 is ignored.
- Upstream may stall at any point mid-frame; cnt holds.
- Consumer may hold out_ready high permanently; frames are then presented for exactly one cycle each.

## Structure
- Shared package mpu_pkg holds:
  - MPU_ELEM_W=8, MPU_ELEMS=25, MPU_MATRIX_W=200, MPU_FRAME_LEN=26;
  - the 2-value state enum (S_LOAD, S_FULL);
  - a function mapping (col,row) to a bit offset, used by loader, multiplier and bench alike.
- No sub-module: a single always block for state/counter plus one for data capture, with byte-lane write decode by cnt.

## Test plan
- Reset, then 26 bytes with no stalls (factor=3, elements e = e-12, in_last on byte 25):
  - out_valid one cycle after the last byte;
  - out_factor=3; out_matrix[0 +: 8]=-12, [8*24 +: 8]=12; element (col1,row2) at bits [56 +: 8]=-5.
- Same frame with out_ready=0 for 10 cycles:
  - out_valid and data stable;
  - in_ready=0 throughout;
  - out_ready=1 ends presentation, and in_ready=1 the following cycle.
- Short frame, in_last on byte 10:
  - err pulse one cycle later; no out_valid;
  - the next valid 26-byte frame is presented correctly.
- Long frame, byte 25 without in_last:
  - err pulse; no out_valid;
  - counter restarts at 0, verified by a following good frame.
- Random in_valid gaps plus back-to-back frames with out_ready tied high:
  - each frame presented exactly once;
  - factor -128 and elements 127/-128 preserved bit-exact.
- rst asserted at byte 13 and again during S_FULL:
  - outputs return to reset values the next cycle; no err;
  - a fresh frame loads correctly.
